// File: rtl/cp0_exception_commit.sv
// CP0 commit: takes one exception/ERET per handshake, updates EPC/Cause/Status/BadVAddr/EntryHi, owns Count/Compare.
// Registers update one cycle after acceptance; redirect_valid holds until redirect_ready, and no report is accepted meanwhile.
module cp0_exception_commit #(
  parameter logic [31:0] VEC_BASE    = 32'hBFC0_0200,
  parameter logic [31:0] VEC_BASE_NB = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        exc_valid,
  output logic        exc_ready,
  input  logic [4:0]  exc_code,
  input  logic [31:0] exc_pc,
  input  logic [31:0] exc_vaddr,
  input  logic        exc_has_vaddr,
  input  logic        exc_in_delay_slot,
  input  logic        exc_tlb_refill,
  input  logic        eret_valid,
  input  logic        mtc0_en,
  input  logic [4:0]  mtc0_addr,
  input  logic [31:0] mtc0_wdata,
  input  logic [5:0]  ext_int,
  output logic        redirect_valid,
  input  logic        redirect_ready,
  output logic [31:0] redirect_pc,
  output logic [31:0] cp0_status,
  output logic [31:0] cp0_cause,
  output logic [31:0] cp0_epc,
  output logic [31:0] cp0_badvaddr,
  output logic [31:0] cp0_entryhi,
  output logic        timer_interrupt
);

  localparam logic [4:0]  REG_COUNT   = 5'd9;
  localparam logic [4:0]  REG_ENTRYHI = 5'd10;
  localparam logic [4:0]  REG_COMPARE = 5'd11;
  localparam logic [4:0]  REG_STATUS  = 5'd12;
  localparam logic [4:0]  REG_CAUSE   = 5'd13;
  localparam logic [4:0]  REG_EPC     = 5'd14;

  localparam logic [31:0] STATUS_RST   = 32'h0040_0000;
  localparam logic [31:0] STATUS_WMASK = 32'h0040_FF03;
  localparam logic [31:0] ENTRYHI_WMASK = 32'hFFFF_E0FF;
  localparam logic [31:0] VEC_OFF_GEN  = 32'h0000_0180;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_REDIRECT = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [31:0] status_q, status_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] badvaddr_q, badvaddr_d;
  logic [31:0] entryhi_q, entryhi_d;
  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        cause_bd_q, cause_bd_d;
  logic [4:0]  cause_exc_q, cause_exc_d;
  logic [1:0]  cause_ip_sw_q, cause_ip_sw_d;
  logic [5:0]  ip_hw_q;
  logic        ti_q, ti_d;
  logic        tick_q, tick_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;

  logic        accept_exc;
  logic        accept_eret;
  logic        old_exl;
  logic        tlb_code;
  logic [31:0] vec_base;
  logic [31:0] vec_target;
  logic [31:0] count_inc;

  // FSM: state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    if (state_q == ST_IDLE) begin
      if (exc_valid || eret_valid) begin
        state_d = ST_REDIRECT;
      end
    end else if (redirect_ready) begin
      state_d = ST_IDLE;
    end
  end

  // FSM: outputs, a function of state only
  always_comb begin
    exc_ready      = (state_q == ST_IDLE);
    redirect_valid = (state_q == ST_REDIRECT);
  end

  assign accept_exc  = exc_ready && exc_valid;
  assign accept_eret = exc_ready && eret_valid && !exc_valid;

  assign old_exl    = status_q[1];
  assign tlb_code   = (exc_code >= 5'd1) && (exc_code <= 5'd3);
  assign vec_base   = status_q[22] ? VEC_BASE : VEC_BASE_NB;
  assign vec_target = vec_base + ((exc_tlb_refill && !old_exl) ? 32'd0 : VEC_OFF_GEN);
  assign count_inc  = count_q + 32'd1;

  // MTC0 applies first; an accepted exception or ERET then overrides its own fields.
  always_comb begin
    status_d      = status_q;
    epc_d         = epc_q;
    badvaddr_d    = badvaddr_q;
    entryhi_d     = entryhi_q;
    compare_d     = compare_q;
    cause_bd_d    = cause_bd_q;
    cause_exc_d   = cause_exc_q;
    cause_ip_sw_d = cause_ip_sw_q;
    redirect_pc_d = redirect_pc_q;
    tick_d        = ~tick_q;
    count_d       = tick_q ? count_inc : count_q;
    ti_d          = ti_q | (tick_q && (count_inc == compare_q));

    if (mtc0_en) begin
      case (mtc0_addr)
        REG_COUNT: begin
          count_d = mtc0_wdata;
          tick_d  = 1'b0;
          ti_d    = ti_q;
        end
        REG_ENTRYHI: entryhi_d = (entryhi_q & ~ENTRYHI_WMASK) | (mtc0_wdata & ENTRYHI_WMASK);
        REG_COMPARE: begin
          compare_d = mtc0_wdata;
          ti_d      = 1'b0;
        end
        REG_STATUS:  status_d = (status_q & ~STATUS_WMASK) | (mtc0_wdata & STATUS_WMASK);
        REG_CAUSE:   cause_ip_sw_d = mtc0_wdata[9:8];
        REG_EPC:     epc_d = mtc0_wdata;
        default: ;
      endcase
    end

    if (accept_exc) begin
      // A nested exception (EXL already set) must not lose the original return point.
      if (!old_exl) begin
        epc_d      = exc_in_delay_slot ? (exc_pc - 32'd4) : exc_pc;
        cause_bd_d = exc_in_delay_slot;
      end
      cause_exc_d = exc_code;
      status_d[1] = 1'b1;
      if (exc_has_vaddr) begin
        badvaddr_d = exc_vaddr;
        if (tlb_code) begin
          entryhi_d[31:13] = exc_vaddr[31:13];
        end
      end
      redirect_pc_d = vec_target;
    end else if (accept_eret) begin
      status_d[1]   = 1'b0;
      redirect_pc_d = epc_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      status_q      <= STATUS_RST;
      epc_q         <= 32'd0;
      badvaddr_q    <= 32'd0;
      entryhi_q     <= 32'd0;
      count_q       <= 32'd0;
      compare_q     <= 32'd0;
      cause_bd_q    <= 1'b0;
      cause_exc_q   <= 5'd0;
      cause_ip_sw_q <= 2'd0;
      ip_hw_q       <= 6'd0;
      ti_q          <= 1'b0;
      tick_q        <= 1'b0;
      redirect_pc_q <= 32'd0;
    end else begin
      status_q      <= status_d;
      epc_q         <= epc_d;
      badvaddr_q    <= badvaddr_d;
      entryhi_q     <= entryhi_d;
      count_q       <= count_d;
      compare_q     <= compare_d;
      cause_bd_q    <= cause_bd_d;
      cause_exc_q   <= cause_exc_d;
      cause_ip_sw_q <= cause_ip_sw_d;
      ip_hw_q       <= ext_int;
      ti_q          <= ti_d;
      tick_q        <= tick_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  assign redirect_pc     = redirect_pc_q;
  assign cp0_status      = status_q;
  assign cp0_epc         = epc_q;
  assign cp0_badvaddr    = badvaddr_q;
  assign cp0_entryhi     = entryhi_q;
  assign timer_interrupt = ti_q;
  assign cp0_cause       = {cause_bd_q, ti_q, 14'd0, ip_hw_q[5] | ti_q, ip_hw_q[4:0],
                            cause_ip_sw_q, 1'b0, cause_exc_q, 2'b00};

endmodule
